// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: packet geometry, slot positions and loader states.
package vliw_pkg;

   localparam int SLOTS  = 10;
   localparam int SLOT_W = 32;
   localparam int PKT_W  = SLOTS * SLOT_W;
   localparam int DEPTH  = 1024;
   localparam int AW     = $clog2(DEPTH);

   // Slot positions inside a packet; slot 0 occupies the most significant word.
   localparam int SLOT_ADD0  = 0;
   localparam int SLOT_ADD1  = 1;
   localparam int SLOT_MUL   = 2;
   localparam int SLOT_FADD0 = 3;
   localparam int SLOT_FADD1 = 4;
   localparam int SLOT_FMUL  = 5;
   localparam int SLOT_LOGIC = 6;
   localparam int SLOT_LDR   = 7;
   localparam int SLOT_STR   = 8;
   localparam int SLOT_MOV   = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } loader_state_e;

   // Most significant bit of a slot word within a packet.
   function automatic int slot_msb(input int slot);
      return PKT_W - 1 - SLOT_W * slot;
   endfunction

endpackage

// File: rtl/packet_assembler.sv
// Collects slot words into a packet buffer. The outgoing packet is the buffer
// merged with the word being accepted, so a completing word is visible in the
// same cycle it is accepted. Slots never written stay zero (NOP).
module packet_assembler
   import vliw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              accept,
   input  logic [SLOT_W-1:0] data,
   input  logic              last,
   output logic              complete,
   output logic [PKT_W-1:0]  packet
);

   localparam int IW = $clog2(SLOTS);

   logic [IW-1:0]    idx_r;
   logic [PKT_W-1:0] buf_r;
   logic [PKT_W-1:0] merged_s;
   logic             complete_s;

   // Merge the incoming word into its slot and detect packet completion.
   always_comb begin
      merged_s   = buf_r;
      complete_s = 1'b0;
      if (accept) begin
         merged_s[slot_msb(int'(idx_r)) -: SLOT_W] = data;
         complete_s = (idx_r == IW'(SLOT_MOV)) || last;
      end else begin
         complete_s = 1'b0;
      end
   end

   // Slot index and buffer: clear on completion so the next word starts a fresh packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= '0;
         buf_r <= '0;
      end else if (clr) begin
         idx_r <= '0;
         buf_r <= '0;
      end else if (accept) begin
         if (complete_s) begin
            idx_r <= '0;
            buf_r <= '0;
         end else begin
            idx_r <= idx_r + IW'(1);
            buf_r <= merged_s;
         end
      end
   end

   assign complete = complete_s;
   assign packet   = merged_s;

endmodule

// File: rtl/inst_packet_loader.sv
// Instruction-memory loader: streams slot words into packets and writes them
// to consecutive addresses from a programmable base, flagging overflow at the
// top of memory.
module inst_packet_loader
   import vliw_pkg::*;
#(
   parameter int SLOTS_P  = SLOTS,
   parameter int SLOT_W_P = SLOT_W,
   parameter int PKT_W_P  = PKT_W,
   parameter int DEPTH_P  = DEPTH,
   parameter int AW_P     = AW
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [AW_P-1:0]     base_addr,
   input  logic                in_valid,
   input  logic [SLOT_W_P-1:0] in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                wr_en,
   output logic [AW_P-1:0]     wr_addr,
   output logic [PKT_W_P-1:0]  wr_packet,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [AW_P:0]       pkt_count
);

   localparam int CW = AW_P + 1;
   localparam logic [AW_P-1:0] TOP_ADDR = AW_P'(DEPTH_P - 1);

   loader_state_e state_r;
   loader_state_e state_n;

   logic [AW_P-1:0]    addr_r;
   logic [CW-1:0]      pkt_count_r;
   logic               wr_en_r;
   logic [AW_P-1:0]    wr_addr_r;
   logic [PKT_W_P-1:0] wr_packet_r;
   logic               in_ready_r;
   logic               busy_r;
   logic               done_r;
   logic               err_r;

   logic               start_ok_s;
   logic               accept_s;
   logic               last_acc_s;
   logic               complete_s;
   logic [PKT_W-1:0]   packet_s;

   packet_assembler u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok_s),
      .accept   (accept_s),
      .data     (in_data),
      .last     (in_last),
      .complete (complete_s),
      .packet   (packet_s)
   );

   // Handshake qualification and start acceptance.
   always_comb begin
      accept_s   = in_valid && in_ready_r;
      last_acc_s = accept_s && in_last;
      start_ok_s = 1'b0;
      if ((state_r == ST_IDLE) || (state_r == ST_ERR)) begin
         start_ok_s = start;
      end else begin
         start_ok_s = 1'b0;
      end
   end

   // Next-state logic for the load sequence.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_n = ST_LOAD;
            else       state_n = ST_IDLE;
         end
         ST_LOAD: begin
            if (complete_s) begin
               if (last_acc_s)               state_n = ST_FLUSH;
               else if (addr_r == TOP_ADDR)  state_n = ST_ERR;
               else                          state_n = ST_LOAD;
            end else begin
               state_n = ST_LOAD;
            end
         end
         ST_FLUSH: state_n = ST_DONE;
         ST_DONE:  state_n = ST_IDLE;
         ST_ERR: begin
            if (start) state_n = ST_LOAD;
            else       state_n = ST_ERR;
         end
         default:  state_n = ST_IDLE;
      endcase
   end

   // State register and status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         in_ready_r <= (state_n == ST_LOAD);
         busy_r     <= (state_n == ST_LOAD) || (state_n == ST_FLUSH);
         done_r     <= (state_n == ST_DONE);
      end
   end

   // Address counter, packet count, write port and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r      <= '0;
         pkt_count_r <= '0;
         wr_en_r     <= 1'b0;
         wr_addr_r   <= '0;
         wr_packet_r <= '0;
         err_r       <= 1'b0;
      end else begin
         wr_en_r <= 1'b0;
         if (start_ok_s) begin
            addr_r      <= base_addr;
            pkt_count_r <= '0;
            err_r       <= 1'b0;
         end else begin
            if (complete_s) begin
               wr_en_r     <= 1'b1;
               wr_addr_r   <= addr_r;
               wr_packet_r <= packet_s;
               pkt_count_r <= pkt_count_r + CW'(1);
               // The address saturates at the top of memory instead of wrapping.
               if (addr_r != TOP_ADDR) addr_r <= addr_r + AW_P'(1);
            end
            if (state_n == ST_ERR) err_r <= 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign wr_en     = wr_en_r;
   assign wr_addr   = wr_addr_r;
   assign wr_packet = wr_packet_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_inst_packet_loader.sv
// Directed bench for inst_packet_loader: a table of load programs plus
// hand-written sequences for overflow, reset mid-load, latency and start
// filtering.
module tb_inst_packet_loader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [9:0]   base_addr;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_last;
   logic         in_ready;
   logic         wr_en;
   logic [9:0]   wr_addr;
   logic [319:0] wr_packet;
   logic         busy;
   logic         done;
   logic         err;
   logic [10:0]  pkt_count;

   int n_cmp = 0;
   int n_bad = 0;

   inst_packet_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_packet (wr_packet),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   // Write and done capture, sampled mid-cycle.
   logic [9:0]   waddr_q[$];
   logic [319:0] wpkt_q[$];
   int           done_cnt = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         waddr_q.push_back(wr_addr);
         wpkt_q.push_back(wr_packet);
      end
      if (done) done_cnt++;
   end

   typedef struct {
      logic [9:0]  base;
      int          nwords;
      bit          with_last;
      bit          toggle;
      logic [31:0] seed;
      int          exp_writes;
      logic [10:0] exp_count;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [319:0] exp_pkt(input logic [31:0] seed, input int j, input int n);
      logic [319:0] p;
      p = '0;
      for (int k = 0; k < 10; k++) begin
         if (j * 10 + k < n) p[319 - 32 * k -: 32] = seed + 32'(j * 10 + k);
      end
      return p;
   endfunction

   task automatic do_start(input logic [9:0] b);
      start     = 1'b1;
      base_addr = b;
      tick();
      start     = 1'b0;
   endtask

   // Offer n words (seed, seed+1, ...); with toggle, in_valid drops every other cycle.
   task automatic send_words(input int n, input logic [31:0] seed, input bit wlast, input bit toggle);
      int  i;
      int  budget;
      bit  phase;
      bit  acc;
      i = 0;
      budget = 0;
      phase = 1'b0;
      while (i < n && budget < 200) begin
         if (toggle && phase) begin
            in_valid = 1'b0;
            in_data  = 32'hFFFF_FFFF;
            in_last  = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = seed + 32'(i);
            in_last  = wlast && (i == n - 1);
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) i++;
         phase = ~phase;
         budget++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: accepted %0d of %0d words", i, n);
      end
   endtask

   task automatic wait_done(input int d0);
      for (int c = 0; c < 12 && done_cnt == d0; c++) tick();
      chk("done_pulse", 320'(done_cnt - d0), 320'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int w0;
      int d0;
      w0 = waddr_q.size();
      d0 = done_cnt;
      do_start(v.base);
      send_words(v.nwords, v.seed, v.with_last, v.toggle);
      wait_done(d0);
      chk("num_writes", 320'(waddr_q.size() - w0), 320'(v.exp_writes));
      for (int j = 0; j < v.exp_writes && (w0 + j) < waddr_q.size(); j++) begin
         chk("wr_addr", 320'(waddr_q[w0 + j]), 320'(v.base + 10'(j)));
         chk("wr_packet", wpkt_q[w0 + j], exp_pkt(v.seed, j, v.nwords));
      end
      chk("pkt_count", 320'(pkt_count), 320'(v.exp_count));
      chk("err_clear", 320'(err), 320'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", 320'(in_ready), 320'd0);
      chk("rst_wr_en", 320'(wr_en), 320'd0);
      chk("rst_wr_addr", 320'(wr_addr), 320'd0);
      chk("rst_wr_packet", wr_packet, 320'd0);
      chk("rst_busy", 320'(busy), 320'd0);
      chk("rst_done", 320'(done), 320'd0);
      chk("rst_err", 320'(err), 320'd0);
      chk("rst_pkt_count", 320'(pkt_count), 320'd0);
   endtask

   initial begin
      int   w0;
      int   d0;
      vec_t r;

      vecs[0] = '{10'd5,    20, 1'b1, 1'b0, 32'h0000_0001, 2, 11'd2};
      vecs[1] = '{10'd100,  13, 1'b1, 1'b0, 32'h0000_0001, 2, 11'd2};
      vecs[2] = '{10'd0,     1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 11'd1};
      vecs[3] = '{10'd1022, 20, 1'b1, 1'b0, 32'h1234_0000, 2, 11'd2};
      vecs[4] = '{10'd7,    10, 1'b1, 1'b0, 32'h0BAD_0000, 1, 11'd1};
      vecs[5] = '{10'd50,   30, 1'b1, 1'b0, 32'hA500_0000, 3, 11'd3};
      vecs[6] = '{10'd200,  11, 1'b1, 1'b1, 32'h0000_0C00, 2, 11'd2};

      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      tick();
      tick();
      chk_reset_vals();
      rst_n = 1'b1;
      tick();

      // Table of load programs.
      for (int i = 0; i < 7; i++) begin
         w0 = waddr_q.size();
         run_vec(vecs[i]);
         if (i == 0 && waddr_q.size() > w0) begin
            chk("slot0_word1", 320'(wpkt_q[w0][319:288]), 320'h1);
            chk("slot9_word10", 320'(wpkt_q[w0][31:0]), 320'hA);
         end
         tick();
      end

      // Single-word program: write one cycle after acceptance, done one later.
      do_start(10'd300);
      in_valid = 1'b1;
      in_data  = 32'hCAFE_F00D;
      in_last  = 1'b1;
      chk("single_ready", 320'(in_ready), 320'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("single_wr_en", 320'(wr_en), 320'd1);
      chk("single_wr_addr", 320'(wr_addr), 320'd300);
      chk("single_packet", wr_packet, {32'hCAFE_F00D, 288'd0});
      chk("single_done_early", 320'(done), 320'd0);
      chk("single_busy_flush", 320'(busy), 320'd1);
      chk("single_ready_flush", 320'(in_ready), 320'd0);
      chk("single_count", 320'(pkt_count), 320'd1);
      tick();
      chk("single_done", 320'(done), 320'd1);
      chk("single_busy_done", 320'(busy), 320'd0);
      chk("single_wr_en_off", 320'(wr_en), 320'd0);
      tick();
      chk("single_done_off", 320'(done), 320'd0);
      tick();

      // Overflow at the top address: write happens, then ERR blocks further input.
      w0 = waddr_q.size();
      do_start(10'd1023);
      send_words(10, 32'h7000_0000, 1'b0, 1'b0);
      chk("ovf_wr_en", 320'(wr_en), 320'd1);
      chk("ovf_wr_addr", 320'(wr_addr), 320'd1023);
      chk("ovf_err", 320'(err), 320'd1);
      chk("ovf_ready", 320'(in_ready), 320'd0);
      chk("ovf_busy", 320'(busy), 320'd0);
      in_valid = 1'b1;
      in_data  = 32'h7000_000A;
      repeat (3) tick();
      chk("ovf_ready_held", 320'(in_ready), 320'd0);
      chk("ovf_err_sticky", 320'(err), 320'd1);
      in_valid = 1'b0;
      chk("ovf_writes", 320'(waddr_q.size() - w0), 320'd1);
      if (waddr_q.size() > w0) chk("ovf_packet", wpkt_q[w0], exp_pkt(32'h7000_0000, 0, 10));
      do_start(10'd0);
      chk("ovf_err_cleared", 320'(err), 320'd0);
      chk("ovf_restart_busy", 320'(busy), 320'd1);
      chk("ovf_restart_count", 320'(pkt_count), 320'd0);
      d0 = done_cnt;
      send_words(1, 32'h0000_0001, 1'b1, 1'b0);
      wait_done(d0);
      tick();

      // Start during LOAD is ignored: the load continues at the original base.
      w0 = waddr_q.size();
      d0 = done_cnt;
      do_start(10'd40);
      send_words(5, 32'h0000_4000, 1'b0, 1'b0);
      start     = 1'b1;
      base_addr = 10'd77;
      tick();
      start     = 1'b0;
      send_words(5, 32'h0000_4005, 1'b1, 1'b0);
      wait_done(d0);
      chk("busystart_writes", 320'(waddr_q.size() - w0), 320'd1);
      if (waddr_q.size() > w0) begin
         chk("busystart_addr", 320'(waddr_q[w0]), 320'd40);
         chk("busystart_packet", wpkt_q[w0], exp_pkt(32'h0000_4000, 0, 10));
      end
      chk("busystart_count", 320'(pkt_count), 320'd1);
      tick();

      // Reset after 6 accepted words discards the partial packet.
      w0 = waddr_q.size();
      do_start(10'd3);
      send_words(6, 32'h0000_0600, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      chk_reset_vals();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_no_write", 320'(waddr_q.size() - w0), 320'd0);
      r = '{10'd0, 10, 1'b1, 1'b0, 32'h0000_0100, 1, 11'd1};
      run_vec(r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
